euler_frame_assembler: RTL and testbench

Sits between the BNO055 byte-read sequencer and the attitude encoder. Collects the six Euler register bytes (0x1A–0x1F) delivered one at a time and checks that they arrive in order. Publishes coherent 16-bit heading/roll/pitch words as one atomic frame, so the encoder never sees roll from one sweep mixed with pitch from another. Also flags stale data when the sensor stops delivering frames and, optionally, smooths roll and pitch.

---
 rtl/euler_frame_assembler_pkg.sv | 38 +++
 rtl/euler_frame_assembler_if.sv | 11 +
 rtl/euler_frame_assembler_ema_filter.sv | 32 +++
 rtl/euler_frame_assembler.sv | 130 +++++++++++++
 tb/tb_euler_frame_assembler.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/euler_frame_assembler_pkg.sv
// Shared constants, types and helpers for the BNO055 Euler frame assembler.
// Build option: EULER_AVG_EN enables roll/pitch EMA smoothing in the top level.
package euler_pkg;

  localparam int unsigned EUL_BYTES        = 6;
  localparam int unsigned EUL_IDX_W        = 3;
  localparam int unsigned EUL_WORD_W       = 16;
  localparam logic [7:0]  EUL_BASE_ADDR    = 8'h1A;
  localparam int unsigned EUL_HEADING_FULL = 5760;

  localparam logic [EUL_IDX_W-1:0] EUL_IDX_HEAD_L  = 3'd0;
  localparam logic [EUL_IDX_W-1:0] EUL_IDX_HEAD_H  = 3'd1;
  localparam logic [EUL_IDX_W-1:0] EUL_IDX_ROLL_L  = 3'd2;
  localparam logic [EUL_IDX_W-1:0] EUL_IDX_ROLL_H  = 3'd3;
  localparam logic [EUL_IDX_W-1:0] EUL_IDX_PITCH_L = 3'd4;
  localparam logic [EUL_IDX_W-1:0] EUL_IDX_PITCH_H = 3'd5;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PUBLISH = 1'b1
  } eul_state_t;

  typedef struct packed {
    logic [EUL_WORD_W-1:0] heading;
    logic [EUL_WORD_W-1:0] roll;
    logic [EUL_WORD_W-1:0] pitch;
  } eul_frame_t;

  // Assemble little-endian register pairs into the three Euler words.
  function automatic eul_frame_t eul_pack(input logic [EUL_BYTES-1:0][7:0] b);
    eul_frame_t f;
    f.heading = {b[EUL_IDX_HEAD_H],  b[EUL_IDX_HEAD_L]};
    f.roll    = {b[EUL_IDX_ROLL_H],  b[EUL_IDX_ROLL_L]};
    f.pitch   = {b[EUL_IDX_PITCH_H], b[EUL_IDX_PITCH_L]};
    return f;
  endfunction

endpackage

// File: rtl/euler_frame_assembler_if.sv
// Byte-strobe bus from the BNO055 read sequencer into the frame assembler.
interface euler_frame_assembler_if;
  import euler_pkg::*;

  logic                 i_byte_valid;
  logic [EUL_IDX_W-1:0] i_byte_idx;
  logic [7:0]           i_byte;

  modport master (output i_byte_valid, i_byte_idx, i_byte);
  modport slave  (input  i_byte_valid, i_byte_idx, i_byte);
endinterface

// File: rtl/euler_frame_assembler_ema_filter.sv
// One signed 16-bit EMA axis: y <= y + ((x - y) >>> SHIFT), first load copies x.
module euler_ema_filter #(
  parameter int unsigned SHIFT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [15:0] i_x,
  output logic [15:0] o_y
);

  logic [15:0]        r_y;
  logic               r_primed;
  logic signed [16:0] w_diff;
  logic signed [16:0] w_sum;

  assign w_diff = $signed({i_x[15], i_x}) - $signed({r_y[15], r_y});
  assign w_sum  = $signed({r_y[15], r_y}) + (w_diff >>> SHIFT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y      <= '0;
      r_primed <= 1'b0;
    end else if (i_load) begin
      r_primed <= 1'b1;
      r_y      <= r_primed ? 16'(w_sum) : i_x;
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/euler_frame_assembler.sv
// Collects BNO055 Euler bytes 0x1A..0x1F in order and publishes atomic frames.
// Build option: EULER_AVG_EN routes roll/pitch through euler_ema_filter.
module euler_frame_assembler
  import euler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned AVG_SHIFT      = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  euler_frame_assembler_if.slave   i_bus,
  output logic [EUL_WORD_W-1:0]    o_heading,
  output logic [EUL_WORD_W-1:0]    o_roll,
  output logic [EUL_WORD_W-1:0]    o_pitch,
  output logic                     o_frame_valid,
  output logic                     o_stale,
  output logic                     o_seq_err,
  output logic [7:0]               o_frame_count
);

  localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  if (AVG_SHIFT >= 16) begin : g_shift_range
    $error("AVG_SHIFT must be below 16");
  end

  eul_state_t                  r_state;
  logic [EUL_IDX_W-1:0]        r_exp;
  logic [EUL_BYTES-1:0][7:0]   r_shadow;
  logic [WD_W-1:0]             r_wd;
  logic [EUL_WORD_W-1:0]       r_heading;
  logic                        r_frame_valid;
  logic                        r_stale;
  logic                        r_seq_err;
  logic [7:0]                  r_frame_count;
  eul_frame_t                  w_frame;
  logic                        w_publish;

  assign w_frame   = eul_pack(r_shadow);
  assign w_publish = (r_state == ST_PUBLISH);

  // Byte sequencing, publish and watchdog; a strobe during PUBLISH is still taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_COLLECT;
      r_exp         <= '0;
      r_shadow      <= '0;
      r_wd          <= '0;
      r_heading     <= '0;
      r_frame_valid <= 1'b0;
      r_stale       <= 1'b1;
      r_seq_err     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state <= ST_COLLECT;
      if (i_bus.i_byte_valid) begin
        if (i_bus.i_byte_idx == r_exp) begin
          r_shadow[r_exp] <= i_bus.i_byte;
          if (r_exp == EUL_IDX_PITCH_H) begin
            r_exp   <= '0;
            r_state <= ST_PUBLISH;
          end else begin
            r_exp <= r_exp + EUL_IDX_W'(1);
          end
        end else if (i_bus.i_byte_idx == EUL_IDX_HEAD_L) begin
          r_shadow[EUL_IDX_HEAD_L] <= i_bus.i_byte;
          r_exp                    <= EUL_IDX_HEAD_H;
          r_seq_err                <= 1'b1;
        end else begin
          r_exp     <= '0;
          r_seq_err <= 1'b1;
        end
      end

      r_frame_valid <= w_publish;
      if (w_publish) begin
        r_heading     <= w_frame.heading;
        r_frame_count <= r_frame_count + 8'd1;
        r_wd          <= '0;
        r_stale       <= 1'b0;
      end else if (r_wd == WD_LAST) begin
        r_stale <= 1'b1;
      end else begin
        r_wd <= r_wd + WD_W'(1);
      end
    end
  end

`ifdef EULER_AVG_EN
  euler_ema_filter #(.SHIFT(AVG_SHIFT)) u_roll_ema (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_publish),
    .i_x    (w_frame.roll),
    .o_y    (o_roll)
  );

  euler_ema_filter #(.SHIFT(AVG_SHIFT)) u_pitch_ema (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_publish),
    .i_x    (w_frame.pitch),
    .o_y    (o_pitch)
  );
`else
  logic [EUL_WORD_W-1:0] r_roll;
  logic [EUL_WORD_W-1:0] r_pitch;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_roll  <= '0;
      r_pitch <= '0;
    end else if (w_publish) begin
      r_roll  <= w_frame.roll;
      r_pitch <= w_frame.pitch;
    end
  end

  assign o_roll  = r_roll;
  assign o_pitch = r_pitch;
`endif

  assign o_heading     = r_heading;
  assign o_frame_valid = r_frame_valid;
  assign o_stale       = r_stale;
  assign o_seq_err     = r_seq_err;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_euler_frame_assembler.sv
// Directed bench for euler_frame_assembler with a queue-based reference model.
module tb_euler_frame_assembler;
  import euler_pkg::*;

  localparam int unsigned TMO = 100;
  localparam int unsigned AVG = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] o_heading, o_roll, o_pitch;
  logic        o_frame_valid, o_stale, o_seq_err;
  logic [7:0]  o_frame_count;

  int total = 0;
  int bad   = 0;
  int n_pulses = 0;

  always #5 clk = ~clk;

  euler_frame_assembler_if bus();

  euler_frame_assembler #(.TIMEOUT_CYCLES(TMO), .AVG_SHIFT(AVG)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_bus         (bus),
    .o_heading     (o_heading),
    .o_roll        (o_roll),
    .o_pitch       (o_pitch),
    .o_frame_valid (o_frame_valid),
    .o_stale       (o_stale),
    .o_seq_err     (o_seq_err),
    .o_frame_count (o_frame_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: list of bytes of the frame in progress, published one edge later.
  logic [7:0]  m_part[$];
  logic [15:0] m_heading, m_roll, m_pitch;
  logic [15:0] p_heading, p_roll, p_pitch;
  logic        m_fv, m_stale, m_err, m_pend, m_primed, m_started;
  logic [7:0]  m_cnt;
  int          m_since;

`ifdef EULER_AVG_EN
  function automatic logic [15:0] ema(input logic [15:0] y, input logic [15:0] x);
    int d;
    d = int'($signed(x)) - int'($signed(y));
    return 16'(int'($signed(y)) + (d >>> AVG));
  endfunction
`endif

  initial begin
    m_started = 1'b0;
    forever begin
      @(posedge clk);
      m_started = 1'b1;
      if (rst) begin
        m_part.delete();
        m_heading = '0; m_roll = '0; m_pitch = '0;
        m_fv = 1'b0; m_stale = 1'b1; m_err = 1'b0; m_pend = 1'b0;
        m_primed = 1'b0; m_cnt = '0; m_since = 0;
      end else begin
        if (m_pend) begin
          m_heading = p_heading;
`ifdef EULER_AVG_EN
          m_roll  = m_primed ? ema(m_roll, p_roll)   : p_roll;
          m_pitch = m_primed ? ema(m_pitch, p_pitch) : p_pitch;
`else
          m_roll  = p_roll;
          m_pitch = p_pitch;
`endif
          m_primed = 1'b1;
          m_fv = 1'b1; m_cnt = m_cnt + 8'd1; m_stale = 1'b0; m_since = 0;
        end else begin
          m_fv = 1'b0;
          m_since++;
          if (m_since >= int'(TMO)) m_stale = 1'b1;
        end
        m_pend = 1'b0;
        if (bus.i_byte_valid) begin
          if (int'(bus.i_byte_idx) == m_part.size()) begin
            m_part.push_back(bus.i_byte);
            if (m_part.size() == 6) begin
              p_heading = {m_part[1], m_part[0]};
              p_roll    = {m_part[3], m_part[2]};
              p_pitch   = {m_part[5], m_part[4]};
              m_pend = 1'b1;
              m_part.delete();
            end
          end else if (bus.i_byte_idx == 3'd0) begin
            m_part.delete();
            m_part.push_back(bus.i_byte);
            m_err = 1'b1;
          end else begin
            m_part.delete();
            m_err = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_started) begin
      check("heading",     32'(o_heading),     32'(m_heading));
      check("roll",        32'(o_roll),        32'(m_roll));
      check("pitch",       32'(o_pitch),       32'(m_pitch));
      check("frame_valid", 32'(o_frame_valid), 32'(m_fv));
      check("stale",       32'(o_stale),       32'(m_stale));
      check("seq_err",     32'(o_seq_err),     32'(m_err));
      check("frame_count", 32'(o_frame_count), 32'(m_cnt));
      if (o_frame_valid === 1'b1) n_pulses++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] idx, input logic [7:0] b);
    bus.i_byte_valid = 1'b1;
    bus.i_byte_idx   = idx;
    bus.i_byte       = b;
    tick();
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] h, input logic [15:0] r, input logic [15:0] p);
    send(3'd0, h[7:0]); send(3'd1, h[15:8]);
    send(3'd2, r[7:0]); send(3'd3, r[15:8]);
    send(3'd4, p[7:0]); send(3'd5, p[15:8]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  int p0;

  initial begin
    bus.i_byte_valid = 1'b0;
    bus.i_byte_idx   = '0;
    bus.i_byte       = '0;
    tick();
    do_reset();
    check("rst_stale",   32'(o_stale),       32'd1);
    check("rst_count",   32'(o_frame_count), 32'd0);
    check("rst_heading", 32'(o_heading),     32'd0);
    check("rst_err",     32'(o_seq_err),     32'd0);

    // First frame: literal values from byte pairs.
    send(3'd0, 8'h10); send(3'd1, 8'h00); send(3'd2, 8'h20);
    send(3'd3, 8'hFF); send(3'd4, 8'h40); send(3'd5, 8'h00);
    check("f1_fv_early", 32'(o_frame_valid), 32'd0);
    tick();
    check("f1_fv",      32'(o_frame_valid), 32'd1);
    check("f1_heading", 32'(o_heading),     32'h0010);
    check("f1_roll",    32'(o_roll),        32'hFF20);
    check("f1_pitch",   32'(o_pitch),       32'h0040);
    check("f1_count",   32'(o_frame_count), 32'd1);
    check("f1_stale",   32'(o_stale),       32'd0);

    // Watchdog: stale exactly TMO cycles after the publish.
    repeat (TMO - 1) tick();
    check("wd_before", 32'(o_stale), 32'd0);
    tick();
    check("wd_after",  32'(o_stale), 32'd1);
    send_frame(16'h1234, 16'h5678, 16'h9ABC);
    tick();
    check("f2_heading", 32'(o_heading),     32'h1234);
    check("f2_stale",   32'(o_stale),       32'd0);
    check("f2_count",   32'(o_frame_count), 32'd2);
`ifndef EULER_AVG_EN
    check("f2_roll",    32'(o_roll),        32'h5678);
`endif

    // Out-of-order bytes: no publish, sticky error, then restart via idx 0.
    send(3'd0, 8'h11); send(3'd1, 8'h22); send(3'd3, 8'h33);
    repeat (2) tick();
    check("seq_err",    32'(o_seq_err),     32'd1);
    check("seq_count",  32'(o_frame_count), 32'd2);
    send(3'd0, 8'h01); send(3'd7, 8'h02);
    send(3'd0, 8'h03); send(3'd1, 8'h04); send(3'd2, 8'h05);
    send_frame(16'hBEEF, 16'h0100, 16'hFF00);
    tick();
    check("f3_heading", 32'(o_heading),     32'hBEEF);
    check("f3_count",   32'(o_frame_count), 32'd3);

    // Reset mid-frame discards the partial frame.
    send(3'd0, 8'hAA); send(3'd1, 8'hBB); send(3'd2, 8'hCC); send(3'd3, 8'hDD);
    rst = 1'b1; tick(); rst = 1'b0;
    send(3'd4, 8'hEE); send(3'd5, 8'hFF);
    repeat (3) tick();
    check("mid_rst_heading", 32'(o_heading),     32'd0);
    check("mid_rst_count",   32'(o_frame_count), 32'd0);
    check("mid_rst_roll",    32'(o_roll),        32'd0);

    // Counter wrap over 256 back-to-back frames.
    p0 = n_pulses;
    for (int i = 0; i < 255; i++)
      send_frame(16'(i * 3), 16'(i * 5 + 7), 16'(16'hF000 + i));
    tick();
    check("wrap_255", 32'(o_frame_count), 32'd255);
    send_frame(16'h0FFF, 16'h0001, 16'h0002);
    tick();
    check("wrap_0",    32'(o_frame_count), 32'd0);
    check("wrap_fv",   32'(o_frame_valid), 32'd1);
    repeat (2) tick();
    check("wrap_pulses", 32'(n_pulses - p0), 32'd256);

`ifdef EULER_AVG_EN
    do_reset();
    send_frame(16'h0000, 16'h0000, 16'h0000);
    tick();
    check("ema_first", 32'(o_roll), 32'h0000);
    send_frame(16'h0000, 16'h0100, 16'h0000);
    tick();
    check("ema_second", 32'(o_roll), 32'h0040);
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
